// File: rtl/neopixel_stream_tx_pkg.sv
// Shared constants, FSM encoding and the brightness helper for the
// WS2812-class stream serializer. Timing defaults assume a 16 MHz clock.
package neopixel_stream_tx_pkg;

  // Every colour channel on the wire is one byte
  localparam int CHAN_W = 8;

  // Frame geometry defaults
  localparam int DEF_NUM_LEDS     = 24;
  localparam int DEF_BITS_PER_LED = 24;

  // Bit timing at 16 MHz: 0.375 us / 0.6875 us high, 1.25 us period, 80 us latch
  localparam int DEF_T0H_CYC    = 6;
  localparam int DEF_T1H_CYC    = 11;
  localparam int DEF_TBIT_CYC   = 20;
  localparam int DEF_TRESET_CYC = 1280;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  // Width of the pixel index port; a one-LED strip still gets a 1-bit port
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // c * (b + 1) / 256: b = 255 passes c through, b = 0 blanks it
  function automatic logic [CHAN_W-1:0] scale_channel(input logic [CHAN_W-1:0] c,
                                                      input logic [CHAN_W-1:0] b);
    logic [2*CHAN_W-1:0] prod;
    prod = {{CHAN_W{1'b0}}, c} * ({{CHAN_W{1'b0}}, b} + (2*CHAN_W)'(1));
    return prod[2*CHAN_W-1:CHAN_W];
  endfunction

endpackage

// File: rtl/neopixel_stream_tx_bit_timer.sv
// Single-bit waveform generator: a go pulse starts a bit on the next cycle,
// dout is high for T1H/T0H cycles depending on the bit, then low until the
// bit period ends. bit_end marks the final cycle of the period so the caller
// can chain the next bit with no gap. dout is a flop, so the pin never glitches.
module neopixel_stream_tx_bit_timer
  import neopixel_stream_tx_pkg::*;
#(
  parameter int T0H_CYC  = DEF_T0H_CYC,
  parameter int T1H_CYC  = DEF_T1H_CYC,
  parameter int TBIT_CYC = DEF_TBIT_CYC
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_go,
  input  logic i_bit,
  output logic o_dout,
  output logic o_bit_end
);

  localparam int CNT_W = $clog2(TBIT_CYC);

  logic             r_active;
  logic             r_bit;
  logic             r_dout;
  logic [CNT_W-1:0] r_cnt;
  logic             w_high_end;

  assign w_high_end = (r_cnt == (r_bit ? CNT_W'(T1H_CYC - 1) : CNT_W'(T0H_CYC - 1)));
  assign o_bit_end  = r_active && (r_cnt == CNT_W'(TBIT_CYC - 1));
  assign o_dout     = r_dout;

  // Phase counter: restart on go, stop at the end of the period, drop dout after the high phase
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active <= 1'b0;
      r_bit    <= 1'b0;
      r_dout   <= 1'b0;
      r_cnt    <= '0;
    end else if (i_go) begin
      r_active <= 1'b1;
      r_bit    <= i_bit;
      r_dout   <= 1'b1;
      r_cnt    <= '0;
    end else if (o_bit_end) begin
      r_active <= 1'b0;
      r_dout   <= 1'b0;
      r_cnt    <= '0;
    end else if (r_active) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_high_end) begin
        r_dout <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/neopixel_stream_tx.sv
// Streaming WS2812-class serializer. Pixels arrive over valid/ready into a
// one-entry holding register, are brightness-scaled as they move into the
// shifter, and leave MSB first through the bit timer. A frame ends with a
// latch-low period and a one-cycle done pulse; a starved source aborts the
// frame early and raises the sticky underrun flag.
module neopixel_stream_tx
  import neopixel_stream_tx_pkg::*;
#(
  parameter int NUM_LEDS     = DEF_NUM_LEDS,
  parameter int BITS_PER_LED = DEF_BITS_PER_LED,
  parameter int T0H_CYC      = DEF_T0H_CYC,
  parameter int T1H_CYC      = DEF_T1H_CYC,
  parameter int TBIT_CYC     = DEF_TBIT_CYC,
  parameter int TRESET_CYC   = DEF_TRESET_CYC
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  input  logic [CHAN_W-1:0]              i_brightness,
  input  logic [BITS_PER_LED-1:0]        i_pix_data,
  input  logic                           i_pix_valid,
  output logic                           o_pix_ready,
  output logic [idx_width(NUM_LEDS)-1:0] o_pix_index,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_underrun,
  output logic                           o_dout
);

  localparam int NUM_CH    = BITS_PER_LED / CHAN_W;
  localparam int IDX_W     = idx_width(NUM_LEDS);
  localparam int REQ_W     = $clog2(NUM_LEDS + 1);
  localparam int BIT_W     = $clog2(BITS_PER_LED);
  localparam int WAIT_W    = $clog2(TRESET_CYC);
  localparam int STALL_LIM = (TRESET_CYC / 2 > 0) ? TRESET_CYC / 2 : 1;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [BITS_PER_LED-1:0] r_hold;
  logic                    r_hold_valid;
  logic [BITS_PER_LED-1:0] r_shift;       // bits still to send after the current one
  logic [BIT_W-1:0]        r_bit_cnt;
  logic [REQ_W-1:0]        r_req_cnt;     // pixels accepted from the source
  logic [REQ_W-1:0]        r_load_cnt;    // pixels moved into the shifter
  logic [WAIT_W-1:0]       r_wait_cnt;    // stall time in FETCH, latch time in LATCH
  logic                    r_underrun;
  logic                    r_done;

  logic                    w_busy;
  logic                    w_ready;
  logic                    w_xfer;
  logic                    w_avail;
  logic                    w_pending;
  logic                    w_last_bit;
  logic                    w_stall_exp;
  logic                    w_latch_end;
  logic                    w_bit_end;
  logic                    w_load;
  logic                    w_shift;
  logic                    w_go;
  logic                    w_go_bit;
  logic [BITS_PER_LED-1:0] w_raw;
  logic [BITS_PER_LED-1:0] w_scaled;

  assign w_busy      = (r_state != ST_IDLE);
  assign w_ready     = w_busy && !r_hold_valid && (r_req_cnt < REQ_W'(NUM_LEDS))
                       && (r_state != ST_LATCH);
  assign w_xfer      = i_pix_valid && w_ready;
  // A pixel arriving this cycle is usable at once, so an empty holding
  // register never costs a cycle at a load point.
  assign w_avail     = r_hold_valid || w_xfer;
  assign w_pending   = (r_load_cnt < REQ_W'(NUM_LEDS));
  assign w_last_bit  = (r_bit_cnt == BIT_W'(BITS_PER_LED - 1));
  assign w_stall_exp = (r_wait_cnt == WAIT_W'(STALL_LIM - 1));
  assign w_latch_end = (r_wait_cnt == WAIT_W'(TRESET_CYC - 1));

  assign w_raw = r_hold_valid ? r_hold : i_pix_data;

  // Per-channel brightness scaling, brightness sampled at the load itself
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_scale
      assign w_scaled[gi*CHAN_W +: CHAN_W] =
        scale_channel(w_raw[gi*CHAN_W +: CHAN_W], i_brightness);
    end
  endgenerate

  neopixel_stream_tx_bit_timer #(
    .T0H_CYC  (T0H_CYC),
    .T1H_CYC  (T1H_CYC),
    .TBIT_CYC (TBIT_CYC)
  ) u_bit_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_go      (w_go),
    .i_bit     (w_go_bit),
    .o_dout    (o_dout),
    .o_bit_end (w_bit_end)
  );

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // FSM next-state: fetch, shift, reload back-to-back or fall back to fetch, then latch
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (i_start) w_state_next = ST_FETCH;
      ST_FETCH: begin
        if (w_avail)          w_state_next = ST_SHIFT;
        else if (w_stall_exp) w_state_next = ST_LATCH;
      end
      ST_SHIFT: begin
        if (w_bit_end && w_last_bit) begin
          if (!w_pending)    w_state_next = ST_LATCH;
          else if (!w_avail) w_state_next = ST_FETCH;
        end
      end
      ST_LATCH: if (w_latch_end) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: when to load a new pixel, when to advance a bit, and what the timer sends next
  always_comb begin
    w_load  = 1'b0;
    w_shift = 1'b0;
    unique case (r_state)
      ST_FETCH: w_load = w_avail;
      ST_SHIFT: begin
        if (w_bit_end) begin
          if (!w_last_bit)                 w_shift = 1'b1;
          else if (w_pending && w_avail)   w_load  = 1'b1;
        end
      end
      default: ;
    endcase
    w_go     = w_load || w_shift;
    w_go_bit = w_load ? w_scaled[BITS_PER_LED-1] : r_shift[BITS_PER_LED-1];
  end

  // Holding register: fills from the source, empties into the shifter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_hold_valid <= 1'b0;
    end else if (w_load) begin
      r_hold_valid <= 1'b0;
    end else if (w_xfer) begin
      r_hold       <= i_pix_data;
      r_hold_valid <= 1'b1;
    end
  end

  // Shifter and bit position within the current pixel
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_load) begin
      r_shift   <= {w_scaled[BITS_PER_LED-2:0], 1'b0};
      r_bit_cnt <= '0;
    end else if (w_shift) begin
      r_shift   <= r_shift << 1;
      r_bit_cnt <= r_bit_cnt + BIT_W'(1);
    end
  end

  // Frame counters, cleared by an accepted start
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req_cnt  <= '0;
      r_load_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      if (i_start) begin
        r_req_cnt  <= '0;
        r_load_cnt <= '0;
      end
    end else begin
      if (w_xfer) r_req_cnt  <= r_req_cnt + REQ_W'(1);
      if (w_load) r_load_cnt <= r_load_cnt + REQ_W'(1);
    end
  end

  // Shared wait counter: restarts on every state change
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_state_next != r_state) begin
      r_wait_cnt <= '0;
    end else if ((r_state == ST_FETCH) || (r_state == ST_LATCH)) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
  end

  // Status flags: sticky underrun on starvation, done pulse as the latch ends
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_underrun <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == ST_LATCH) && w_latch_end;
      if ((r_state == ST_IDLE) && i_start) begin
        r_underrun <= 1'b0;
      end else if ((r_state == ST_FETCH) && !w_avail && w_stall_exp) begin
        r_underrun <= 1'b1;
      end
    end
  end

  assign o_busy      = w_busy;
  assign o_pix_ready = w_ready;
  assign o_done      = r_done;
  assign o_underrun  = r_underrun;
  assign o_pix_index = (r_req_cnt >= REQ_W'(NUM_LEDS)) ? IDX_W'(NUM_LEDS - 1)
                                                       : IDX_W'(r_req_cnt);

endmodule
